seven_seg_scan_ctrl: RTL and testbench

- Display controller for the FPGA seven-segment bank.
- Accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Commits the digits atomically, then time-multiplexes them onto a common-anode display.
- Instantiates seven_seg_decoder once on the shared segment bus; segment encoding is {g,f,e,d,c,b,a}, active-low.

---
 rtl/seven_seg_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment bank controller: binary-to-BCD via shift-add-3, atomic digit commit,
// and common-anode scan with leading-zero and overflow blanking.

module seven_seg_decoder (
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   // {g,f,e,d,c,b,a}, active-low; anything above 9 (incl. the 4'hF blank code) is dark
   always_comb begin
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   end
endmodule

// state   | meaning
// IDLE    | in_ready high, waiting for a value
// CONVERT | one double-dabble iteration per cycle, BIN_W cycles
// COMMIT  | copy BCD result and overflow into the display registers
module seven_seg_scan_ctrl #(
   parameter int BIN_W       = 14,
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [BIN_W-1:0]      in_data,
   output logic                  in_ready,
   input  logic                  blank_en,
   output logic                  busy,
   output logic                  ovf,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg
);
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam int          BCD_W = 4 * NUM_DIGITS;
   localparam int          CNT_W = $clog2(BIN_W + 1);
   localparam int          IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int          REF_W = $clog2(REFRESH_DIV);
   localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [BCD_W-1:0]  dig_q, dig_d;
   logic              ovf_q, ovf_d;
   logic              idle_c, busy_c;

   logic [REF_W-1:0]      ref_cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic [6:0]            seg_q, seg_dec;
   logic [NUM_DIGITS-1:0] blank_vec;
   logic                  zero_above;
   logic [3:0]            sel_nib;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         dig_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         dig_q   <= dig_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      dig_d   = dig_q;
      ovf_d   = ovf_q;
      idle_c  = 1'b0;
      busy_c  = 1'b0;
      bcd_adj = bcd_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
      case (state_q)
         IDLE: begin
            idle_c = 1'b1;
            if (in_valid) begin
               bin_d   = in_data;
               bcd_d   = '0;
               cnt_d   = '0;
               pend_d  = (64'(in_data) >= LIMIT);
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            busy_c = 1'b1;
            // the bit shifted out of the top nibble is a lost carry
            {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
            if (bcd_adj[BCD_W-1]) pend_d = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
         end
         COMMIT: begin
            dig_d   = bcd_q;
            ovf_d   = pend_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready = idle_c && rst_n;
   assign busy     = busy_c;
   assign ovf      = ovf_q;

   always_comb begin
      zero_above = 1'b1;
      blank_vec  = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_above   = zero_above && (dig_q[4*k +: 4] == 4'd0);
         blank_vec[k] = ovf_q || (blank_en && (k != 0) && zero_above);
      end
      sel_nib = blank_vec[idx_q] ? 4'hF : dig_q[4*idx_q +: 4];
   end

   seven_seg_decoder u_dec (
      .digit (sel_nib),
      .seg   (seg_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt_q <= '0;
         idx_q     <= '0;
         an_q      <= '1;
         seg_q     <= '1;
      end else begin
         if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_q <= '0;
            idx_q     <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end else begin
            ref_cnt_q <= ref_cnt_q + REF_W'(1);
         end
         an_q  <= ~(NUM_DIGITS'(1) << idx_q);
         seg_q <= seg_dec;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with a fast refresh (REFRESH_DIV=4).

module tb_seven_seg_scan_ctrl;
   localparam int BIN_W = 14;
   localparam int ND    = 4;
   localparam int RD    = 4;

   typedef struct {
      int v;
      int at;
   } pend_t;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b1;
   logic             in_valid = 1'b0;
   logic [BIN_W-1:0] in_data  = '0;
   logic             blank_en = 1'b0;
   logic             in_ready, busy, ovf;
   logic [ND-1:0]    an;
   logic [6:0]       seg;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int sb[$];

   seven_seg_scan_ctrl #(.BIN_W(BIN_W), .NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .blank_en (blank_en),
      .busy     (busy),
      .ovf      (ovf),
      .an       (an),
      .seg      (seg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int p10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input int k, input logic blank);
      if (v >= p10(ND)) return 7'b1111111;
      if (blank && k > 0 && v < p10(k)) return 7'b1111111;
      return glyph((v / p10(k)) % 10);
   endfunction

   function automatic int an_index(input logic [ND-1:0] a);
      int idx = -1;
      logic [ND-1:0] m;
      for (int k = 0; k < ND; k++) begin
         m = ~(ND'(1) << k);
         if (a === m) idx = k;
      end
      return idx;
   endfunction

   task automatic check_display(input int v, input logic blank, input string tag);
      int k;
      logic [ND-1:0] seen;
      seen = '0;
      for (int i = 0; i < ND * RD; i++) begin
         @(negedge clk);
         k = an_index(an);
         n_tests++;
         if (k < 0) begin
            n_fail++;
            $display("FAIL %s an_onehot: got %b", tag, an);
         end else begin
            seen[k] = 1'b1;
            if (seg !== exp_seg(v, k, blank)) begin
               n_fail++;
               $display("FAIL %s seg digit%0d: got %b expected %b", tag, k, seg, exp_seg(v, k, blank));
            end
         end
      end
      n_tests++;
      if (seen !== {ND{1'b1}}) begin
         n_fail++;
         $display("FAIL %s scan_coverage: got %b expected %b", tag, seen, {ND{1'b1}});
      end
   endtask

   task automatic send(input int v);
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = BIN_W'(v);
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL handshake_timeout: in_ready got %b expected 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '1;
      sb.push_back(v);
   endtask

   task automatic check_commit(input logic blank, input string tag);
      int busy_cnt, t, v;
      busy_cnt = 0;
      t = 0;
      while (t < 100) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         else break;
         t++;
      end
      n_tests++;
      if (busy_cnt !== BIN_W) begin
         n_fail++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, BIN_W);
      end
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s scoreboard_empty: got 0 entries expected 1", tag);
         return;
      end
      v = sb.pop_front();
      @(posedge clk);
      #1;
      n_tests++;
      if (ovf !== 1'(v >= p10(ND))) begin
         n_fail++;
         $display("FAIL %s ovf: got %b expected %b", tag, ovf, (v >= p10(ND)));
      end
      @(posedge clk);
      check_display(v, blank, tag);
   endtask

   task automatic test_reset();
      logic [ND-1:0] ea;
      #1 rst_n = 1'b0;
      #10;
      n_tests++;
      if (an !== {ND{1'b1}} || seg !== 7'b1111111) begin
         n_fail++;
         $display("FAIL reset_outputs: got an=%b seg=%b expected an=1111 seg=1111111", an, seg);
      end
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy=%b busy=%b ovf=%b expected 0 0 0", in_ready, busy, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= ND * RD; n++) begin
         @(negedge clk);
         ea = ~(ND'(1) << ((n - 1) / RD));
         n_tests++;
         if (an !== ea || seg !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_scan edge%0d: got an=%b seg=%b expected an=%b seg=1000000", n, an, seg, ea);
         end
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_convert();
      blank_en = 1'b0;
      send(1234);
      check_commit(1'b0, "conv_1234");
   endtask

   task automatic test_blanking();
      blank_en = 1'b1;
      send(7);
      check_commit(1'b1, "blank_7");
      send(0);
      check_commit(1'b1, "blank_0");
      blank_en = 1'b0;
   endtask

   task automatic test_overflow();
      blank_en = 1'b0;
      send(12000);
      check_commit(1'b0, "ovf_12000");
      send(42);
      check_commit(1'b0, "ovf_then_42");
   endtask

   task automatic test_back_to_back();
      pend_t pq[$];
      pend_t p;
      int vals[4] = '{1234, 9876, 305, 16383};
      int n_acc, last_hs, hs, k;
      n_acc = 0;
      last_hs = -1;
      blank_en = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = BIN_W'(vals[0]);
      for (int c = 0; c < 400 && (n_acc < 4 || pq.size() > 0); c++) begin
         if (pq.size() > 0 && pq[0].at <= cyc) begin
            p = pq.pop_front();
            k = an_index(an);
            n_tests++;
            if (k < 0 || seg !== exp_seg(p.v, k, 1'b0)) begin
               n_fail++;
               $display("FAIL b2b_display v=%0d: got an=%b seg=%b expected digit seg=%b", p.v, an, seg,
                        exp_seg(p.v, (k < 0) ? 0 : k, 1'b0));
            end
         end
         if (in_ready && in_valid) begin
            hs = cyc + 1;
            if (last_hs >= 0) begin
               n_tests++;
               if (hs - last_hs !== BIN_W + 2) begin
                  n_fail++;
                  $display("FAIL b2b_spacing: got %0d cycles expected %0d", hs - last_hs, BIN_W + 2);
               end
            end
            last_hs = hs;
            p.v  = vals[n_acc];
            p.at = hs + BIN_W + 2;
            pq.push_back(p);
            n_acc++;
            @(posedge clk);
            #1;
            if (n_acc < 4) in_data = BIN_W'(vals[n_acc]);
            else begin
               in_valid = 1'b0;
               in_data  = '0;
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (n_acc < 4 || pq.size() > 0) begin
         n_fail++;
         $display("FAIL b2b_timeout: got accepted=%0d pending=%0d expected 4 and 0", n_acc, pq.size());
      end
      check_display(16383, 1'b0, "b2b_last");
   endtask

   task automatic test_reset_mid_convert();
      blank_en = 1'b0;
      send(9999);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (an !== {ND{1'b1}} || seg !== 7'b1111111 || busy !== 1'b0 || in_ready !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: got an=%b seg=%b busy=%b rdy=%b ovf=%b expected 1111 1111111 0 0 0",
                  an, seg, busy, in_ready, ovf);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      check_display(0, 1'b0, "midrst_after");
      n_tests++;
      if (ovf !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_flags: got ovf=%b busy=%b expected 0 0", ovf, busy);
      end
   endtask

   initial begin
      test_reset();
      test_convert();
      test_blanking();
      test_overflow();
      test_back_to_back();
      test_reset_mid_convert();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
